// File: rtl/mips_pkg.sv
// Shared constants for the MIPS register file: default geometry, the
// hardwired-zero index and the stack-pointer reset value.
package mips_pkg;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 5;
  localparam int REG_ZERO    = 0;
  localparam int REG_SP_IDX  = 29;
  localparam int REG_SP_INIT = 252;
endpackage

// File: rtl/regfile_sb_cnt.sv
// One pending-write counter: counts issued-but-unretired writes to a single
// register, saturating at all-ones, cleared by flush.
module regfile_sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             decNow,
  output logic             satHit
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // A writeback only retires something when a write is actually pending.
  assign decNow = dec && (cnt != '0);
  assign satHit = inc && !decNow && !flush && (cnt == CNT_MAX);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (inc && !decNow) begin
      if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
    end else if (decNow && !inc) begin
      cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-read-port MIPS register file with WB->ID bypass and a per-register
// pending-write scoreboard that drives per-operand busy flags.
module mips_regfile_mp
  import mips_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_RD  = 2,
  parameter int CNT_W   = 2,
  parameter int SP_IDX  = REG_SP_IDX,
  parameter int SP_INIT = REG_SP_INIT
) (
  input  logic                     Clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic                     sb_ovf
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  cntArr [DEPTH];
  logic [DEPTH-1:0]  decArr;
  logic [DEPTH-1:0]  satVec;

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
      end
    end else if (wr_en && (wr_addr != ZERO_IDX)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign cntArr[0] = '0;
  assign decArr[0] = 1'b0;
  assign satVec[0] = 1'b0;

  for (genvar r = 1; r < DEPTH; r++) begin : g_cnt
    regfile_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .Clk    (Clk),
      .reset_n(reset_n),
      .flush  (flush),
      .inc    (iss_en && (iss_addr == ADDR_W'(r))),
      .dec    (wr_en && (wr_addr == ADDR_W'(r))),
      .cnt    (cntArr[r]),
      .decNow (decArr[r]),
      .satHit (satVec[r])
    );
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_ovf <= 1'b0;
    end else if (|satVec) begin
      sb_ovf <= 1'b1;
    end
  end

  // A write retiring this cycle is bypassed, so it must not report busy.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    logic [ADDR_W-1:0] rdIdx;
    logic              bypassHit;
    assign rdIdx     = rd_addr[k*ADDR_W +: ADDR_W];
    assign bypassHit = wr_en && (wr_addr == rdIdx) && (rdIdx != ZERO_IDX);
    assign rd_data[k*DATA_W +: DATA_W] = bypassHit ? wr_data : mem[rdIdx];
    assign rd_busy[k] = (cntArr[rdIdx] - CNT_W'(decArr[rdIdx])) != '0;
  end
endmodule

// File: tb/tb_mips_regfile_mp.sv
// Randomised and directed bench for mips_regfile_mp against a behavioural
// array/counter model of the register file and scoreboard.
module tb_mips_regfile_mp;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int NUM_RD  = 2;
  localparam int CNT_W   = 2;
  localparam int DEPTH   = 32;
  localparam int CNT_MAX = 3;

  logic                     Clk = 1'b0;
  logic                     reset_n;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     flush;
  logic                     sb_ovf;

  int nChecks = 0;
  int nPass   = 0;

  logic [DATA_W-1:0] mMem [DEPTH];
  int                mCnt [DEPTH];
  logic              mOvf;

  mips_regfile_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .CNT_W(CNT_W),
    .SP_IDX(29), .SP_INIT(252)
  ) dut (
    .Clk(Clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .sb_ovf(sb_ovf)
  );

  always #5 Clk = ~Clk;

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      mMem[i] = (i == 29) ? 32'd252 : 32'd0;
      mCnt[i] = 0;
    end
    mOvf = 1'b0;
  endtask

  // State change at a clock edge, straight from the register-file rules.
  task automatic modelEdge();
    if (wr_en && wr_addr != 0) mMem[wr_addr] = wr_data;
    if (flush) begin
      for (int r = 0; r < DEPTH; r++) mCnt[r] = 0;
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        bit inc, dec;
        inc = iss_en && (int'(iss_addr) == r);
        dec = wr_en && (int'(wr_addr) == r) && (mCnt[r] != 0);
        if (inc && !dec) begin
          if (mCnt[r] == CNT_MAX) mOvf = 1'b1;
          else mCnt[r] = mCnt[r] + 1;
        end else if (dec && !inc) begin
          mCnt[r] = mCnt[r] - 1;
        end
      end
    end
  endtask

  function automatic logic [DATA_W-1:0] expData(int a);
    if (a == 0) return '0;
    if (wr_en && int'(wr_addr) == a) return wr_data;
    return mMem[a];
  endfunction

  function automatic logic expBusy(int a);
    int c;
    if (a == 0) return 1'b0;
    c = mCnt[a];
    if (wr_en && int'(wr_addr) == a && c > 0) c = c - 1;
    return c != 0;
  endfunction

  function automatic logic [DATA_W-1:0] portData(int k);
    return rd_data[k*DATA_W +: DATA_W];
  endfunction

  task automatic setRd(int k, int a);
    rd_addr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  task automatic idle();
    wr_en = 0; iss_en = 0; flush = 0;
    wr_addr = '0; iss_addr = '0; wr_data = '0;
  endtask

  task automatic tick();
    @(posedge Clk);
    if (reset_n) modelEdge();
    #1;
  endtask

  task automatic test_reset();
    idle();
    setRd(0, 0); setRd(1, 29);
    reset_n = 0;
    modelReset();
    #2;
    nChecks++;
    if (portData(1) !== 32'd252) $display("FAIL reset_sp_during got=%0d want=252", portData(1));
    else nPass++;
    repeat (2) @(posedge Clk);
    #1 reset_n = 1;
    #2;
    nChecks++;
    if (portData(0) !== 32'd0) $display("FAIL reset_r0 got=%h want=0", portData(0));
    else nPass++;
    nChecks++;
    if (portData(1) !== 32'd252) $display("FAIL reset_sp got=%0d want=252", portData(1));
    else nPass++;
    nChecks++;
    if (rd_busy !== 2'b00 || sb_ovf !== 1'b0)
      $display("FAIL reset_flags busy=%b ovf=%b want busy=00 ovf=0", rd_busy, sb_ovf);
    else nPass++;
    tick();
  endtask

  task automatic test_bypass();
    idle();
    setRd(0, 8); setRd(1, 0);
    wr_en = 1; wr_addr = 8; wr_data = 32'h1;
    #2;
    nChecks++;
    if (portData(0) !== 32'h1) $display("FAIL bypass_same got=%h want=1", portData(0));
    else nPass++;
    tick();
    idle();
    #2;
    nChecks++;
    if (portData(0) !== 32'h1) $display("FAIL bypass_later got=%h want=1", portData(0));
    else nPass++;
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFF_FFFF;
    #2;
    nChecks++;
    if (portData(1) !== 32'h0) $display("FAIL r0_write_same got=%h want=0", portData(1));
    else nPass++;
    tick();
    idle();
    #2;
    nChecks++;
    if (portData(1) !== 32'h0 || rd_busy[1] !== 1'b0)
      $display("FAIL r0_write_after data=%h busy=%b want 0/0", portData(1), rd_busy[1]);
    else nPass++;
  endtask

  task automatic test_scoreboard();
    idle();
    setRd(0, 9); setRd(1, 9);
    iss_en = 1; iss_addr = 9;
    #2;
    nChecks++;
    if (rd_busy[0] !== 1'b0) $display("FAIL issue_same_cycle busy=%b want=0", rd_busy[0]);
    else nPass++;
    tick(); tick();
    idle();
    #2;
    nChecks++;
    if (rd_busy !== 2'b11) $display("FAIL sb_two_pending busy=%b want=11", rd_busy);
    else nPass++;
    wr_en = 1; wr_addr = 9; wr_data = 32'hAAAA_0001;
    #2;
    nChecks++;
    if (rd_busy[0] !== 1'b1) $display("FAIL sb_first_wr busy=%b want=1", rd_busy[0]);
    else nPass++;
    tick();
    wr_data = 32'hBBBB_0002;
    #2;
    nChecks++;
    if (rd_busy[0] !== 1'b0 || portData(0) !== 32'hBBBB_0002)
      $display("FAIL sb_retire busy=%b data=%h want 0/bbbb0002", rd_busy[0], portData(0));
    else nPass++;
    tick();
    idle();
  endtask

  task automatic test_simultaneous();
    idle();
    setRd(0, 10); setRd(1, 11);
    iss_en = 1; iss_addr = 10; tick();
    wr_en = 1; wr_addr = 10; wr_data = 32'h1010;
    tick();
    idle();
    #2;
    nChecks++;
    if (rd_busy[0] !== 1'b1) $display("FAIL iss_wr_same busy=%b want=1", rd_busy[0]);
    else nPass++;
    iss_en = 1; iss_addr = 11;
    repeat (3) tick();
    flush = 1;
    tick();
    idle();
    #2;
    nChecks++;
    if (rd_busy !== 2'b00) $display("FAIL flush_clear busy=%b want=00", rd_busy);
    else nPass++;
  endtask

  task automatic test_saturation();
    idle();
    setRd(0, 12);
    iss_en = 1; iss_addr = 12;
    repeat (4) tick();
    idle();
    #2;
    nChecks++;
    if (rd_busy[0] !== 1'b1 || sb_ovf !== 1'b1)
      $display("FAIL sat_set busy=%b ovf=%b want 1/1", rd_busy[0], sb_ovf);
    else nPass++;
    flush = 1; tick(); idle();
    repeat (3) tick();
    nChecks++;
    if (sb_ovf !== 1'b1) $display("FAIL sat_sticky ovf=%b want=1", sb_ovf);
    else nPass++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int k = 0; k < NUM_RD; k++)
        setRd(k, ($urandom_range(0, 9) == 0) ? 29 : $urandom_range(0, 7));
      wr_en    = ($urandom_range(0, 2) != 0);
      wr_addr  = ADDR_W'($urandom_range(0, 7));
      wr_data  = $urandom;
      iss_en   = ($urandom_range(0, 1) == 1);
      iss_addr = ADDR_W'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 19) == 0);
      #2;
      for (int k = 0; k < NUM_RD; k++) begin
        int a;
        a = int'(rd_addr[k*ADDR_W +: ADDR_W]);
        nChecks++;
        if (portData(k) !== expData(a) || rd_busy[k] !== expBusy(a)) begin
          errs++;
          if (errs < 10)
            $display("FAIL rand_port%0d cyc=%0d addr=%0d data=%h busy=%b want %h/%b",
                     k, cyc, a, portData(k), rd_busy[k], expData(a), expBusy(a));
        end else nPass++;
      end
      nChecks++;
      if (sb_ovf !== mOvf) begin
        errs++;
        if (errs < 10) $display("FAIL rand_ovf cyc=%0d got=%b want=%b", cyc, sb_ovf, mOvf);
      end else nPass++;
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    setRd(0, 13); setRd(1, 29);
    iss_en = 1; iss_addr = 13;
    tick(); tick();
    idle();
    wr_en = 1; wr_addr = 13; wr_data = 32'h55;
    #2 reset_n = 0;
    modelReset();
    @(posedge Clk);
    #1 idle();
    reset_n = 1;
    #2;
    nChecks++;
    if (portData(0) !== 32'h0 || rd_busy[0] !== 1'b0)
      $display("FAIL rst_mid data=%h busy=%b want 0/0", portData(0), rd_busy[0]);
    else nPass++;
    nChecks++;
    if (sb_ovf !== 1'b0 || portData(1) !== 32'd252)
      $display("FAIL rst_mid_state ovf=%b sp=%0d want 0/252", sb_ovf, portData(1));
    else nPass++;
    wr_en = 1; wr_addr = 13; wr_data = 32'h77;
    tick();
    idle();
    #2;
    nChecks++;
    if (portData(0) !== 32'h77 || rd_busy[0] !== 1'b0)
      $display("FAIL rst_first_wr data=%h busy=%b want 77/0", portData(0), rd_busy[0]);
    else nPass++;
  endtask

  initial begin
    rd_addr = '0;
    reset_n = 1;
    idle();
    modelReset();
    #1;
    test_reset();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
